game_display_ctrl: RTL and testbench
====================================

GAME_DISPLAY_CTRL -- requirements
Module: game_display_ctrl

Interface
REQ-001 Parameter: VERT_RES, 480, first non-visible line; the frame boundary is line VERT_RES, pixel 0.
REQ-002 Parameter: REVEAL_FRAMES, 60, number of frames the REVEAL state is held.
REQ-003 Parameter: MAX_SCORE, 99, score saturation value.
REQ-004 clk_100MHz  in  1  system clock; the only clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 i_hcounter, i_vcounter  in  10 each  pixel position from the VGA sync block; quasi-static for at least 4 clk_100MHz cycles.
REQ-007 btn_start, btn_higher, btn_lower, btn_confirm  in  1 each  debounced single-cycle button pulses.
REQ-008 o_fsm_state  out  3  display state code: 0 IDLE, 1 DEAL, 2 GUESS, 3 REVEAL, 4 GAME_OVER.
REQ-009 o_cur_card, o_next_card  out  4 each  card values, range 1..13.
REQ-010 o_score  out  7  current streak.
REQ-011 o_guess  out  2  latched guess: 0 none, 1 higher, 2 lower.
REQ-012 o_win  out  1  result of the current reveal.
REQ-013 o_frame_pulse  out  1  one-cycle pulse at each frame boundary.

Function
REQ-014 Frame pulse: register the condition (i_vcounter==VERT_RES && i_hcounter==0) and emit one cycle on its rising edge only, giving exactly one pulse per frame.
REQ-015 Card source: free-running 8-bit LFSR, taps x^8+x^6+x^5+x^4+1, steps every cycle, never reaches zero.
REQ-016 Card mapping: v=lfsr[3:0]; card = 1 if v==0; v-13 if v>13; v otherwise.
REQ-017 IDLE: btn_start loads cur_card from the mapped card, clears score and guess, and moves to DEAL; all other buttons are ignored.
REQ-018 DEAL: unconditional move to GUESS after 1 cycle.
REQ-019 GUESS: btn_higher latches guess=1 and btn_lower latches guess=2; a later press overwrites the guess; both pressed in the same cycle leaves the guess unchanged.
REQ-020 GUESS: btn_confirm with guess≠0 loads next_card from the mapped card, computes win, clears the frame counter, and moves to REVEAL; btn_confirm with guess==0 is ignored.
REQ-021 Win: higher wins when next>cur and lower wins when next<cur; equal cards are covered by REQ-030.
REQ-022 REVEAL: count frame pulses; on reaching REVEAL_FRAMES, a win leads to GUESS with score+1 (saturating at MAX_SCORE), cur_card<=next_card, and guess cleared; a loss leads to GAME_OVER.
REQ-023 GAME_OVER: btn_start returns to IDLE; score is held until the next game starts.
REQ-024 Display outputs (o_fsm_state, o_cur_card, o_next_card, o_score, o_guess, o_win) are shadow registers updated only in the o_frame_pulse cycle.
REQ-025 An internal update coincident with o_frame_pulse is not captured; the shadow takes the pre-update value, and the new value appears at the next frame.
REQ-026 Latency: from a state change to the visible output is ≤1 frame plus 1 cycle.
REQ-027 Button pulses in states not listed above have no effect.

Reset
REQ-028 Reset (any cycle, including mid-REVEAL) sets: state IDLE; all outputs 0, including o_cur_card and o_next_card, where 0 is the only out-of-range value permitted; frame counter 0; o_frame_pulse 0; LFSR 8'hA5.
REQ-029 Reset has priority over all buttons and over frame pulses in the same cycle.

Configuration
REQ-030 Macro HL_TIE_WIN_EN: when defined, next==cur is a win for either guess; when undefined, next==cur is a loss.

Structure
REQ-031 Package hl_game_pkg holds: the state encoding (0..4), CARD_W=4, SCORE_W=7, MAX_SCORE, LFSR_SEED=8'hA5.
REQ-032 Sub-module hl_lfsr8 implements the LFSR (clk_100MHz, reset, 8-bit state out); card mapping stays in game_display_ctrl.

Verification
REQ-033 Reset, then one frame: o_fsm_state=0, score=0, exactly one o_frame_pulse per 800x525 pixel frame.
REQ-034 Force cur=5, next=9, guess higher, confirm: REVEAL visible next frame; after 60 frame pulses state=2, score=1, cur_card=9.
REQ-035 Force cur=9, next=3, guess higher: after 60 frames, o_fsm_state=4; btn_start then returns state 0 at the next frame.
REQ-036 Force cur=7, next=7: state=2 with HL_TIE_WIN_EN defined, state=4 without.
REQ-037 btn_confirm with no guess, btn_higher and btn_lower together, and btn_start asserted on a frame-pulse cycle: first two ignored; start shows DEAL/GUESS one frame later.
REQ-038 Reset asserted at frame 30 of REVEAL with score=98: next cycle state=IDLE, all outputs 0; drive 100 wins: score saturates at 99.

Source files
------------

// File: rtl/hl_game_pkg.sv
// Shared types and constants for the higher/lower card game display controller.
// Latency: n/a (types only); backpressure: n/a.
package hl_game_pkg;

    localparam int         CARD_W    = 4;
    localparam int         SCORE_W   = 7;
    localparam int         MAX_SCORE = 99;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DEAL      = 3'd1,
        ST_GUESS     = 3'd2,
        ST_REVEAL    = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        GUESS_NONE   = 2'd0,
        GUESS_HIGHER = 2'd1,
        GUESS_LOWER  = 2'd2
    } guess_t;

    typedef struct packed {
        state_t               state;
        logic [CARD_W-1:0]    cur_card;
        logic [CARD_W-1:0]    next_card;
        logic [SCORE_W-1:0]   score;
        guess_t               guess;
        logic                 win;
    } game_t;

endpackage

// File: rtl/hl_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, maximal length from a non-zero seed.
// Latency: new value every cycle; no backpressure.
module hl_lfsr8
    import hl_game_pkg::*;
(
    input  logic       clk_100MHz,
    input  logic       reset,
    output logic [7:0] lfsr
);

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

endmodule

// File: rtl/game_display_ctrl.sv
// Higher/lower card game FSM with frame-synchronous display shadows; HL_TIE_WIN_EN makes equal cards a win.
// Latency: display follows internal state within one frame plus one cycle; no backpressure, buttons are consumed or dropped.
module game_display_ctrl #(
    parameter int VERT_RES      = 480,
    parameter int REVEAL_FRAMES = 60,
    parameter int MAX_SCORE     = hl_game_pkg::MAX_SCORE
) (
    input  logic                            clk_100MHz,
    input  logic                            reset,
    input  logic [9:0]                      i_hcounter,
    input  logic [9:0]                      i_vcounter,
    input  logic                            btn_start,
    input  logic                            btn_higher,
    input  logic                            btn_lower,
    input  logic                            btn_confirm,
    output logic [2:0]                      o_fsm_state,
    output logic [hl_game_pkg::CARD_W-1:0]  o_cur_card,
    output logic [hl_game_pkg::CARD_W-1:0]  o_next_card,
    output logic [hl_game_pkg::SCORE_W-1:0] o_score,
    output logic [1:0]                      o_guess,
    output logic                            o_win,
    output logic                            o_frame_pulse
);
    import hl_game_pkg::*;

    localparam logic [9:0] VERT_LINE = 10'(VERT_RES);
    localparam int         FCNT_W    = $clog2(REVEAL_FRAMES + 1);
`ifdef HL_TIE_WIN_EN
    localparam bit TIE_WINS = 1'b1;
`else
    localparam bit TIE_WINS = 1'b0;
`endif

    logic [7:0]         lfsr;
    logic               lfsr_unused;
    logic [CARD_W-1:0]  card;
    logic               at_boundary_q;
    logic               at_boundary_q2;
    logic [FCNT_W-1:0]  frame_cnt;
    logic [FCNT_W-1:0]  frame_cnt_d;
    game_t              game;
    game_t              game_d;
    game_t              shadow;

    function automatic logic [CARD_W-1:0] card_map(input logic [3:0] v);
        if (v == 4'd0) return 4'd1;
        if (v > 4'd13) return v - 4'd13;
        return v;
    endfunction

    function automatic logic guess_wins(input guess_t g, input logic [CARD_W-1:0] cur,
                                        input logic [CARD_W-1:0] nxt);
        return ((g == GUESS_HIGHER) && (nxt > cur)) ||
               ((g == GUESS_LOWER)  && (nxt < cur)) ||
               (TIE_WINS && (nxt == cur));
    endfunction

    hl_lfsr8 u_lfsr (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .lfsr       (lfsr)
    );

    assign card        = card_map(lfsr[3:0]);
    assign lfsr_unused = ^lfsr[7:4];

    // The boundary pixel is held for several cycles; only its first cycle produces a pulse.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            at_boundary_q  <= 1'b0;
            at_boundary_q2 <= 1'b0;
        end else begin
            at_boundary_q  <= (i_vcounter == VERT_LINE) && (i_hcounter == 10'd0);
            at_boundary_q2 <= at_boundary_q;
        end
    end

    assign o_frame_pulse = at_boundary_q & ~at_boundary_q2;

    always_comb begin
        game_d      = game;
        frame_cnt_d = frame_cnt;
        case (game.state)
            ST_IDLE: begin
                if (btn_start) begin
                    game_d.cur_card = card;
                    game_d.score    = '0;
                    game_d.guess    = GUESS_NONE;
                    game_d.state    = ST_DEAL;
                end
            end
            ST_DEAL: game_d.state = ST_GUESS;
            ST_GUESS: begin
                if (btn_confirm && (game.guess != GUESS_NONE)) begin
                    game_d.next_card = card;
                    game_d.win       = guess_wins(game.guess, game.cur_card, card);
                    frame_cnt_d      = '0;
                    game_d.state     = ST_REVEAL;
                end else if (btn_higher && !btn_lower) begin
                    game_d.guess = GUESS_HIGHER;
                end else if (btn_lower && !btn_higher) begin
                    game_d.guess = GUESS_LOWER;
                end
            end
            ST_REVEAL: begin
                if (o_frame_pulse) begin
                    frame_cnt_d = frame_cnt + 1'b1;
                    if (frame_cnt == FCNT_W'(REVEAL_FRAMES - 1)) begin
                        if (game.win) begin
                            game_d.state    = ST_GUESS;
                            game_d.cur_card = game.next_card;
                            game_d.guess    = GUESS_NONE;
                            if (game.score != SCORE_W'(MAX_SCORE)) begin
                                game_d.score = game.score + SCORE_W'(1);
                            end
                        end else begin
                            game_d.state = ST_GAME_OVER;
                        end
                    end
                end
            end
            ST_GAME_OVER: begin
                if (btn_start) game_d.state = ST_IDLE;
            end
            default: game_d.state = ST_IDLE;
        endcase
    end

    // Shadows sample the pre-update game state, so a coincident change shows one frame later.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            game      <= '0;
            frame_cnt <= '0;
            shadow    <= '0;
        end else begin
            game      <= game_d;
            frame_cnt <= frame_cnt_d;
            if (o_frame_pulse) shadow <= game;
        end
    end

    assign o_fsm_state = shadow.state;
    assign o_cur_card  = shadow.cur_card;
    assign o_next_card = shadow.next_card;
    assign o_score     = shadow.score;
    assign o_guess     = shadow.guess;
    assign o_win       = shadow.win;

endmodule

// File: tb/tb_game_display_ctrl.sv
// Directed bench for game_display_ctrl: reference LFSR picks button timing to force specific cards.
module tb_game_display_ctrl;

    localparam int VERT_RES      = 480;
    localparam int REVEAL_FRAMES = 60;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic [9:0] i_hcounter;
    logic [9:0] i_vcounter;
    logic       btn_start, btn_higher, btn_lower, btn_confirm;
    logic [2:0] o_fsm_state;
    logic [3:0] o_cur_card, o_next_card;
    logic [6:0] o_score;
    logic [1:0] o_guess;
    logic       o_win, o_frame_pulse;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_lfsr;
    bit         gen_en = 1'b0;
    int         ph = 4;
    int         cur_m = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    game_display_ctrl #(
        .VERT_RES      (VERT_RES),
        .REVEAL_FRAMES (REVEAL_FRAMES),
        .MAX_SCORE     (99)
    ) dut (
        .clk_100MHz    (clk_100MHz),
        .reset         (reset),
        .i_hcounter    (i_hcounter),
        .i_vcounter    (i_vcounter),
        .btn_start     (btn_start),
        .btn_higher    (btn_higher),
        .btn_lower     (btn_lower),
        .btn_confirm   (btn_confirm),
        .o_fsm_state   (o_fsm_state),
        .o_cur_card    (o_cur_card),
        .o_next_card   (o_next_card),
        .o_score       (o_score),
        .o_guess       (o_guess),
        .o_win         (o_win),
        .o_frame_pulse (o_frame_pulse)
    );

    // Reference card source: x^8+x^6+x^5+x^4+1 from seed 8'hA5.
    always @(posedge clk_100MHz) begin
        if (reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic int card_of(input logic [7:0] s);
        int v;
        v = int'(s[3:0]);
        if (v == 0) return 1;
        if (v > 13) return v - 13;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic abort(input string tag);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", tag);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // One cycle; in generator mode a frame is 4 cycles on pixel (VERT_RES,0) then 1 cycle off it.
    task automatic cyc();
        @(negedge clk_100MHz);
        if (gen_en) begin
            ph         = (ph >= 4) ? 0 : ph + 1;
            i_vcounter = 10'(VERT_RES);
            i_hcounter = (ph == 4) ? 10'd1 : 10'd0;
        end
    endtask

    task automatic press(input logic [3:0] b);
        {btn_start, btn_higher, btn_lower, btn_confirm} = b;
        cyc();
        {btn_start, btn_higher, btn_lower, btn_confirm} = 4'b0000;
    endtask

    task automatic wait_frame();
        int n = 0;
        while (o_frame_pulse !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        if (o_frame_pulse !== 1'b1) abort("frame_timeout");
        cyc();
    endtask

    task automatic wait_card(input int lo, input int hi, output int c);
        int n = 0;
        c = card_of(m_lfsr);
        while ((c < lo || c > hi) && n < 600) begin
            cyc();
            n++;
            c = card_of(m_lfsr);
        end
        if (c < lo || c > hi) abort("card_timeout");
    endtask

    task automatic start_game(input int lo, input int hi);
        int c;
        wait_card(lo, hi, c);
        press(4'b1000);
        cur_m = c;
        cyc();
    endtask

    task automatic arm_winning_guess();
        int c;
        if (cur_m <= 7) begin
            press(4'b0100);
            wait_card(cur_m + 1, 13, c);
        end else begin
            press(4'b0010);
            wait_card(1, cur_m - 1, c);
        end
        press(4'b0001);
        cur_m = c;
    endtask

    task automatic win_round();
        arm_winning_guess();
        repeat (REVEAL_FRAMES) wait_frame();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, o_fsm_state, 0);
        check({tag, "_cur"},   o_cur_card,  0);
        check({tag, "_next"},  o_next_card, 0);
        check({tag, "_score"}, o_score,     0);
        check({tag, "_guess"}, o_guess,     0);
        check({tag, "_win"},   o_win,       0);
        check({tag, "_pulse"}, o_frame_pulse, 0);
    endtask

    initial begin
        #1_500_000;
        abort("global_watchdog");
    end

    initial begin
        int c;
        int n;
        int pulses;
        int hl[4];
        hl = '{0, 1, 400, 799};
        reset = 1'b1;
        {btn_start, btn_higher, btn_lower, btn_confirm} = 4'b0000;
        i_hcounter = 10'd0;
        i_vcounter = 10'd0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        check_all_zero("reset");

        // Scan one 800x525 frame at reduced horizontal density.
        pulses = 0;
        for (int v = 0; v < 525; v++) begin
            for (int k = 0; k < 4; k++) begin
                i_vcounter = 10'(v);
                i_hcounter = 10'(hl[k]);
                repeat (4) begin
                    cyc();
                    if (o_frame_pulse === 1'b1) pulses++;
                end
            end
        end
        check("pulses_per_frame", pulses, 1);
        check("scan_state", o_fsm_state, 0);
        check("scan_score", o_score, 0);

        gen_en = 1'b1;
        ph     = 4;

        // cur=5, next=9, guess higher
        start_game(5, 5);
        press(4'b0100);
        wait_card(9, 9, c);
        press(4'b0001);
        cur_m = 9;
        wait_frame();
        check("rev_state", o_fsm_state, 3);
        check("rev_cur", o_cur_card, 5);
        check("rev_next", o_next_card, 9);
        check("rev_guess", o_guess, 1);
        check("rev_win", o_win, 1);
        repeat (REVEAL_FRAMES - 1) wait_frame();
        check("rev_last_frame_state", o_fsm_state, 3);
        wait_frame();
        check("win_state", o_fsm_state, 2);
        check("win_score", o_score, 1);
        check("win_cur", o_cur_card, 9);
        check("win_guess_cleared", o_guess, 0);

        // cur=9, next=3, guess higher -> loss
        press(4'b0100);
        wait_card(3, 3, c);
        press(4'b0001);
        repeat (REVEAL_FRAMES + 1) wait_frame();
        check("loss_state", o_fsm_state, 4);
        check("loss_score", o_score, 1);
        check("loss_win", o_win, 0);
        check("loss_next", o_next_card, 3);
        press(4'b1000);
        wait_frame();
        check("over_to_idle", o_fsm_state, 0);
        check("over_score_held", o_score, 1);

        // Tie: cur=7, next=7
        start_game(7, 7);
        press(4'b0100);
        wait_card(7, 7, c);
        press(4'b0001);
        repeat (REVEAL_FRAMES + 1) wait_frame();
`ifdef HL_TIE_WIN_EN
        check("tie_state", o_fsm_state, 2);
        check("tie_score", o_score, 1);
`else
        check("tie_state", o_fsm_state, 4);
        check("tie_score", o_score, 0);
`endif
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        cyc();

        // Ignored buttons and start on a frame-pulse cycle
        press(4'b0111);
        wait_frame();
        check("idle_ignores", o_fsm_state, 0);
        n = 0;
        while (o_frame_pulse !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        if (o_frame_pulse !== 1'b1) abort("pulse_wait");
        c = card_of(m_lfsr);
        press(4'b1000);
        cur_m = c;
        check("start_on_pulse_pre", o_fsm_state, 0);
        wait_frame();
        check("start_on_pulse_post", o_fsm_state, 2);
        check("start_card", o_cur_card, 4'(c));
        press(4'b0001);
        press(4'b0110);
        press(4'b0001);
        wait_frame();
        check("confirm_no_guess", o_fsm_state, 2);
        check("both_no_guess", o_guess, 0);
        press(4'b0100);
        press(4'b0110);
        wait_frame();
        check("both_keeps_higher", o_guess, 1);
        press(4'b0010);
        press(4'b1000);
        wait_frame();
        check("lower_overwrites", o_guess, 2);
        check("guess_ignores_start", o_fsm_state, 2);

        // Reach score 98, then reset mid-reveal on a frame-pulse cycle
        repeat (98) win_round();
        wait_frame();
        check("score_98", o_score, 98);
        arm_winning_guess();
        repeat (30) wait_frame();
        n = 0;
        while (o_frame_pulse !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        if (o_frame_pulse !== 1'b1) abort("pulse_wait_reset");
        reset = 1'b1;
        cyc();
        check_all_zero("midreveal_reset");
        reset = 1'b0;
        cyc();
        wait_frame();
        check("post_reset_idle", o_fsm_state, 0);

        // 100 wins from zero: saturates at 99
        start_game(1, 13);
        repeat (99) win_round();
        wait_frame();
        check("score_99", o_score, 99);
        win_round();
        wait_frame();
        check("score_saturated", o_score, 99);
        check("sat_state", o_fsm_state, 2);
        check("sat_cur", o_cur_card, 4'(cur_m));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
